captura_teclado_param: RTL and testbench

- Parametrised keypad front end for the calculator datapath.
- Generates its own scan tick from the system clock and scans a 4x4 matrix keypad.
- Debounces key presses and assembles two multi-digit BCD operands.
- Presents both operands to the adder/7-segment stage through a valid/ack handshake.
- Replaces the fixed divider and the single-digit capture FSM with one configurable block.

---
 rtl/captura_teclado_param.sv | 211 +++++++++++++++++++++
 tb/tb_captura_teclado_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_teclado_param.sv
// Keypad front end: scan tick generation, 4x4 matrix scanning, debounce,
// and two-operand BCD capture with a valid/ack handshake toward the adder stage.
module captura_teclado_param #(
    parameter int CLK_FREQ       = 27000000,
    parameter int SCAN_FREQ      = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int NUM_DIGITS     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              col_in,
    output logic [3:0]              row_out,
    output logic [4*NUM_DIGITS-1:0] operand_a,
    output logic [4*NUM_DIGITS-1:0] operand_b,
    output logic                    data_valid,
    input  logic                    data_ack,
    output logic                    key_pulse,
    output logic [3:0]              key_code,
    output logic [1:0]              capt_state
);
    localparam int TICK_DIV = CLK_FREQ / SCAN_FREQ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int OP_W     = 4 * NUM_DIGITS;
    localparam int CNT_W    = $clog2(NUM_DIGITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]  DIG_MAX   = CNT_W'(NUM_DIGITS);

    typedef enum logic [1:0] {
        CAPT_A = 2'd0,
        CAPT_B = 2'd1,
        DONE   = 2'd2
    } state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        col_meta;
    logic [3:0]        col_sync;
    logic              col_idle;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic [3:0]        scan_code;
    logic              held;
    logic [3:0]        cand_code;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   press_cnt;
    logic [DB_W-1:0]   rel_cnt;
    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  dig_cnt;
    logic [CNT_W-1:0]  dig_nx;
    logic [OP_W-1:0]   op_a_nx;
    logic [OP_W-1:0]   op_b_nx;
    logic [OP_W-1:0]   cur_op;
    logic [OP_W-1:0]   cur_nx;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running scan-tick divider; tick is a clock enable, never a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Two-stage synchroniser for the asynchronous column lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    assign col_idle = &col_sync;

    // Decode the active row and lowest low column into a key code.
    always_comb begin
        col_idx = 2'd3;
        if      (!col_sync[0]) col_idx = 2'd0;
        else if (!col_sync[1]) col_idx = 2'd1;
        else if (!col_sync[2]) col_idx = 2'd2;
        case (row_out)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        case ({row_idx, col_idx})
            4'h0: scan_code = 4'h1;  4'h1: scan_code = 4'h2;
            4'h2: scan_code = 4'h3;  4'h3: scan_code = 4'hA;
            4'h4: scan_code = 4'h4;  4'h5: scan_code = 4'h5;
            4'h6: scan_code = 4'h6;  4'h7: scan_code = 4'hB;
            4'h8: scan_code = 4'h7;  4'h9: scan_code = 4'h8;
            4'hA: scan_code = 4'h9;  4'hB: scan_code = 4'hC;
            4'hC: scan_code = 4'hE;  4'hD: scan_code = 4'h0;
            4'hE: scan_code = 4'hF;  default: scan_code = 4'hD;
        endcase
        // db_cnt counts consecutive sightings of cand_code (0 = no candidate)
        press_cnt = DB_W'(1);
        if (db_cnt != '0 && cand_code == scan_code) press_cnt = db_cnt + 1'b1;
        rel_cnt = db_cnt + 1'b1;
    end

    // Row rotation while the keypad is idle; frozen while any column is low or a key is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           row_out <= 4'b1110;
        else if (tick && col_idle && !held) row_out <= {row_out[2:0], row_out[3]};
    end

    // Press/release debounce; one counter serves both phases since they never overlap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held      <= 1'b0;
            cand_code <= '0;
            db_cnt    <= '0;
            key_pulse <= 1'b0;
            key_code  <= '0;
        end else begin
            key_pulse <= 1'b0;
            if (tick) begin
                if (!held) begin
                    if (col_idle) begin
                        db_cnt <= '0;
                    end else if (press_cnt == DB_LAST) begin
                        key_pulse <= 1'b1;
                        key_code  <= scan_code;
                        held      <= 1'b1;
                        db_cnt    <= '0;
                    end else begin
                        cand_code <= scan_code;
                        db_cnt    <= press_cnt;
                    end
                end else begin
                    if (!col_idle) begin
                        db_cnt <= '0;
                    end else if (rel_cnt == DB_LAST) begin
                        held   <= 1'b0;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= rel_cnt;
                    end
                end
            end
        end
    end

    // Capture FSM state, digit count and operand registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CAPT_A;
            dig_cnt   <= '0;
            operand_a <= '0;
            operand_b <= '0;
        end else begin
            state     <= state_nx;
            dig_cnt   <= dig_nx;
            operand_a <= op_a_nx;
            operand_b <= op_b_nx;
        end
    end

    // Next-state and operand update; the operand being edited is selected by state.
    always_comb begin
        state_nx = state;
        dig_nx   = dig_cnt;
        op_a_nx  = operand_a;
        op_b_nx  = operand_b;
        cur_op   = (state == CAPT_B) ? operand_b : operand_a;
        cur_nx   = cur_op;
        case (state)
            CAPT_A, CAPT_B: begin
                if (key_pulse) begin
                    if (key_code <= 4'd9) begin
                        if (dig_cnt < DIG_MAX) begin
                            cur_nx = (cur_op << 4) | OP_W'(key_code);
                            dig_nx = dig_cnt + 1'b1;
                        end
                    end else if (key_code == 4'hA) begin
                        if (dig_cnt != '0) begin
                            dig_nx   = '0;
                            state_nx = (state == CAPT_A) ? CAPT_B : DONE;
                        end
                    end else if (key_code == 4'hC) begin
                        cur_nx = '0;
                        dig_nx = '0;
                    end
                end
                if (state == CAPT_A) op_a_nx = cur_nx;
                else                 op_b_nx = cur_nx;
            end
            DONE: begin
                if (data_ack) begin
                    state_nx = CAPT_A;
                    dig_nx   = '0;
                    op_a_nx  = '0;
                    op_b_nx  = '0;
                end
            end
            default: state_nx = CAPT_A;
        endcase
    end

    assign capt_state = state;
    assign data_valid = (state == DONE);

endmodule

// File: tb/tb_captura_teclado_param.sv
// Scoreboarded bench: a keypad model drives the columns from row_out, a decimal
// reference model predicts key codes and operands, and a monitor checks outputs.
module tb_captura_teclado_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [11:0] operand_a;
    logic [11:0] operand_b;
    logic        data_valid;
    logic        data_ack;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic [1:0]  capt_state;

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;
    int expected_pulses = 0;

    logic        pressed;
    logic [1:0]  key_r;
    logic [1:0]  key_c;
    logic [3:0]  layout [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                       '{4'h4, 4'h5, 4'h6, 4'hB},
                                       '{4'h7, 4'h8, 4'h9, 4'hC},
                                       '{4'hE, 4'h0, 4'hF, 4'hD}};

    logic [3:0] key_q [$];
    int         exp_a_q [$];
    int         exp_b_q [$];

    int m_state, a_val, b_val, a_n, b_n;

    logic prev_kp = 1'b0;
    logic prev_dv = 1'b0;

    always #5 clk = ~clk;

    captura_teclado_param #(
        .CLK_FREQ(1000),
        .SCAN_FREQ(250),
        .DEBOUNCE_TICKS(2),
        .NUM_DIGITS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .col_in(col_in),
        .row_out(row_out),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .data_valid(data_valid),
        .data_ack(data_ack),
        .key_pulse(key_pulse),
        .key_code(key_code),
        .capt_state(capt_state)
    );

    // Physical keypad: a closed key pulls its column low only while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        if (pressed && !row_out[key_r]) col_in[key_c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        int t = v;
        for (int i = 0; i < 3; i++) begin
            r = r | ((t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; a_val = 0; b_val = 0; a_n = 0; b_n = 0;
    endtask

    task automatic model_key(input logic [3:0] code);
        if (m_state != 2) begin
            if (code <= 4'd9) begin
                if (m_state == 0 && a_n < 3) begin a_val = a_val * 10 + int'(code); a_n++; end
                if (m_state == 1 && b_n < 3) begin b_val = b_val * 10 + int'(code); b_n++; end
            end else if (code == 4'hA) begin
                if (m_state == 0 && a_n > 0) begin
                    m_state = 1;
                end else if (m_state == 1 && b_n > 0) begin
                    m_state = 2;
                    exp_a_q.push_back(to_bcd(a_val));
                    exp_b_q.push_back(to_bcd(b_val));
                end
            end else if (code == 4'hC) begin
                if (m_state == 0) begin a_val = 0; a_n = 0; end
                else begin b_val = 0; b_n = 0; end
            end
        end
    endtask

    task automatic check_model();
        chk("capt_state", 32'(capt_state), 32'(m_state));
        chk("operand_a", 32'(operand_a), 32'(to_bcd(a_val)));
        chk("operand_b", 32'(operand_b), 32'(to_bcd(b_val)));
        chk("data_valid", 32'(data_valid), 32'(m_state == 2));
    endtask

    task automatic locate(input logic [3:0] code);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (layout[r][c] == code) begin
                    key_r = 2'(r);
                    key_c = 2'(c);
                end
    endtask

    task automatic press_key(input logic [3:0] code, input int hold_ticks, input int rel_ticks);
        locate(code);
        key_q.push_back(code);
        expected_pulses++;
        model_key(code);
        pressed = 1'b1;
        repeat (hold_ticks * 4) @(negedge clk);
        pressed = 1'b0;
        repeat (rel_ticks * 4) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        press_key(code, 11, 5);
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) begin
            @(negedge clk);
            chk("valid_hold", 32'(data_valid), 32'd1);
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        model_reset();
        check_model();
    endtask

    // Monitor: every key_pulse pops an expected code; every data_valid rise pops expected operands.
    always @(negedge clk) begin
        if (key_pulse) begin
            pulse_count++;
            chk("pulse_width", 32'(prev_kp), 32'd0);
            if (key_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got code %0h expected no pulse", key_code);
            end else begin
                chk("key_code", 32'(key_code), 32'(key_q.pop_front()));
            end
        end
        if (data_valid && !prev_dv) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_valid 1 expected 0");
            end else begin
                chk("valid_operand_a", 32'(operand_a), 32'(exp_a_q.pop_front()));
                chk("valid_operand_b", 32'(operand_b), 32'(exp_b_q.pop_front()));
            end
        end
        prev_kp = key_pulse;
        prev_dv = data_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_row;
        logic [3:0] exp_rows [0:3];
        int waited;
        exp_rows[0] = 4'b1101; exp_rows[1] = 4'b1011;
        exp_rows[2] = 4'b0111; exp_rows[3] = 4'b1110;

        rst = 1'b0; pressed = 1'b0; data_ack = 1'b0; key_r = 2'd0; key_c = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_row_out", 32'(row_out), 32'hE);
        chk("rst_key_pulse", 32'(key_pulse), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        check_model();
        rst = 1'b1;

        // Idle scan: one rotation step every 4 clocks.
        prev_row = row_out;
        for (int s = 0; s < 4; s++) begin
            waited = 0;
            while (row_out == prev_row && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            chk("row_step", 32'(row_out), 32'(exp_rows[s]));
            chk("row_period", 32'(waited), 32'd4);
            chk("idle_valid", 32'(data_valid), 32'd0);
            prev_row = row_out;
        end

        // Bounce on key 5, aligned so row 1 has just been selected.
        waited = 0;
        while (row_out != 4'b1101 && waited < 40) begin @(negedge clk); waited++; end
        chk("bounce_align", 32'(row_out), 32'hD);
        locate(4'h5);
        for (int t = 0; t < 4; t++) begin
            pressed = (t % 2 == 0);
            repeat (4) @(negedge clk);
        end
        key_q.push_back(4'h5);
        expected_pulses++;
        model_key(4'h5);
        pressed = 1'b1;
        waited = 0;
        while (key_q.size() != 0 && waited < 60) begin @(negedge clk); waited++; end
        chk("bounce_pulse_pending", 32'(key_q.size()), 32'd0);
        for (int t = 0; t < 3; t++) begin
            repeat (4) @(negedge clk);
            chk("row_frozen", 32'(row_out), 32'hD);
        end
        pressed = 1'b0;
        repeat (20) @(negedge clk);
        check_model();
        press(4'hC);
        check_model();

        // Full entry sequence.
        press(4'h1); press(4'h2); press(4'hA);
        press(4'h4); press(4'h5); press(4'h6); press(4'hA);
        chk("entry_a", 32'(operand_a), 32'h012);
        chk("entry_b", 32'(operand_b), 32'h456);
        chk("entry_valid", 32'(data_valid), 32'd1);
        chk("entry_state", 32'(capt_state), 32'd2);
        press(4'h7);
        check_model();

        // Handshake: hold off ack for 10 clocks, then a single-cycle ack.
        do_ack(10);
        chk("ack_a", 32'(operand_a), 32'd0);
        chk("ack_state", 32'(capt_state), 32'd0);

        // Ack outside DONE has no effect.
        press(4'h4);
        data_ack = 1'b1;
        repeat (3) @(negedge clk);
        data_ack = 1'b0;
        chk("stray_ack_a", 32'(operand_a), 32'h004);
        check_model();
        press(4'hC);

        // Overflow, clear, and enter with no digits.
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        chk("overflow_a", 32'(operand_a), 32'h987);
        press(4'hC);
        chk("clear_a", 32'(operand_a), 32'd0);
        chk("clear_state", 32'(capt_state), 32'd0);
        press(4'hA);
        chk("empty_enter_state", 32'(capt_state), 32'd0);
        check_model();

        // Randomised key traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [3:0] code;
            if (m_state == 2 && $urandom_range(0, 2) == 0) begin
                do_ack(int'($urandom_range(0, 5)));
            end else begin
                sel = int'($urandom_range(0, 9));
                if (sel < 6)       code = 4'($urandom_range(0, 9));
                else if (sel < 8)  code = 4'hA;
                else if (sel == 8) code = 4'hC;
                else               code = 4'($urandom_range(0, 15));
                press_key(code, int'($urandom_range(10, 14)), int'($urandom_range(4, 7)));
                check_model();
            end
        end
        if (m_state == 2) do_ack(int'($urandom_range(0, 5)));

        chk("key_q_drained", 32'(key_q.size()), 32'd0);
        chk("valid_q_drained", 32'(exp_a_q.size()), 32'd0);
        chk("pulse_total", 32'(pulse_count), 32'(expected_pulses));

        // Asynchronous reset in the middle of operand B entry.
        press(4'h3); press(4'hA); press(4'h7);
        check_model();
        rst = 1'b0;
        #1;
        chk("async_row_out", 32'(row_out), 32'hE);
        chk("async_operand_a", 32'(operand_a), 32'd0);
        chk("async_operand_b", 32'(operand_b), 32'd0);
        chk("async_valid", 32'(data_valid), 32'd0);
        chk("async_key_pulse", 32'(key_pulse), 32'd0);
        chk("async_key_code", 32'(key_code), 32'd0);
        chk("async_state", 32'(capt_state), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
